// File: rtl/score_digit_renderer.sv
// Three-digit BCD score counter plus a 3-stage pipeline that renders the
// frame-latched score as glyph pixels at a fixed screen location.
module score_digit_renderer #(
  parameter int unsigned X_ORIGIN    = 16,
  parameter int unsigned Y_ORIGIN    = 8,
  parameter int unsigned DIGIT_PITCH = 12
) (
  input  logic        clock_25,
  input  logic        reset,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        score_inc,
  input  logic        score_clear,
  input  logic        number_pixel,
  output logic [3:0]  selected_number,
  output logic [7:0]  number_count,
  output logic        score_pixel,
  output logic [11:0] score_bcd
);

  localparam logic [9:0] LP_X0      = 10'(X_ORIGIN);
  localparam logic [9:0] LP_X_END   = 10'(X_ORIGIN + 3 * DIGIT_PITCH - 1);
  localparam logic [9:0] LP_Y0      = 10'(Y_ORIGIN);
  localparam logic [9:0] LP_Y_END   = 10'(Y_ORIGIN + 9);
  localparam logic [9:0] LP_PITCH   = 10'(DIGIT_PITCH);
  localparam logic [9:0] LP_PITCH2  = 10'(2 * DIGIT_PITCH);
  localparam logic [9:0] LP_GLYPH_W = 10'd10;

  logic [11:0] r_score;
  logic [11:0] r_shadow;
  logic [11:0] w_score_inc;

  logic       w_in_box;
  logic       w_in_glyph;
  logic [9:0] w_hoff;
  logic [9:0] w_voff;
  logic [9:0] w_col_full;
  logic [3:0] w_digit;
  logic [3:0] w_row;
  logic [3:0] w_col;

  logic [3:0] r_row0;
  logic [3:0] r_col0;
  logic       r_glyph0;
  logic       r_glyph1;
  logic [7:0] w_row8;
  logic [7:0] w_count;

  assign score_bcd = r_score;

  // Saturating BCD increment with per-digit decimal carry.
  always_comb begin
    w_score_inc = r_score;
    if (r_score != 12'h999) begin
      if (r_score[3:0] != 4'd9) begin
        w_score_inc[3:0] = r_score[3:0] + 4'd1;
      end else begin
        w_score_inc[3:0] = 4'd0;
        if (r_score[7:4] != 4'd9) begin
          w_score_inc[7:4] = r_score[7:4] + 4'd1;
        end else begin
          w_score_inc[7:4]  = 4'd0;
          w_score_inc[11:8] = r_score[11:8] + 4'd1;
        end
      end
    end
  end

  // Live score; shadow is latched only at scan origin so a frame never tears.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      r_score  <= 12'h000;
      r_shadow <= 12'h000;
    end else begin
      if (score_clear) begin
        r_score <= 12'h000;
      end else if (score_inc) begin
        r_score <= w_score_inc;
      end
      if (h_count == 10'd0 && v_count == 10'd0) begin
        r_shadow <= r_score;
      end
    end
  end

  assign w_in_box = (v_count >= LP_Y0) && (v_count <= LP_Y_END) &&
                    (h_count >= LP_X0) && (h_count <= LP_X_END);
  assign w_hoff   = h_count - LP_X0;
  assign w_voff   = v_count - LP_Y0;

  // Digit select and glyph-local coordinates; everything zero outside a glyph.
  always_comb begin
    w_col_full = 10'd0;
    w_digit    = 4'd0;
    w_in_glyph = 1'b0;
    w_row      = 4'd0;
    w_col      = 4'd0;
    if (w_in_box) begin
      if (w_hoff < LP_PITCH) begin
        w_col_full = w_hoff;
        w_digit    = r_shadow[11:8];
      end else if (w_hoff < LP_PITCH2) begin
        w_col_full = w_hoff - LP_PITCH;
        w_digit    = r_shadow[7:4];
      end else begin
        w_col_full = w_hoff - LP_PITCH2;
        w_digit    = r_shadow[3:0];
      end
      w_in_glyph = (w_col_full < LP_GLYPH_W);
    end
    if (w_in_glyph) begin
      w_row = 4'(w_voff);
      w_col = 4'(w_col_full);
    end else begin
      w_digit = 4'd0;
    end
  end

  // row*10 as shift-and-add; row and col are both 0..9 so the sum fits 0..99.
  assign w_row8  = {4'b0000, r_row0};
  assign w_count = (w_row8 << 3) + (w_row8 << 1) + {4'b0000, r_col0};

  // Stage 0 feeds the ROM; stage 1 aligns the index with ROM data; stage 2 masks.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      selected_number <= 4'd0;
      r_row0          <= 4'd0;
      r_col0          <= 4'd0;
      r_glyph0        <= 1'b0;
      number_count    <= 8'd0;
      r_glyph1        <= 1'b0;
      score_pixel     <= 1'b0;
    end else begin
      selected_number <= w_digit;
      r_row0          <= w_row;
      r_col0          <= w_col;
      r_glyph0        <= w_in_glyph;
      number_count    <= w_count;
      r_glyph1        <= r_glyph0;
      score_pixel     <= number_pixel & r_glyph1;
    end
  end

endmodule

// File: tb/tb_score_digit_renderer.sv
// Directed bench for score_digit_renderer: score counting, frame shadowing,
// pixel pipeline latency/masking and mid-frame reset.
module tb_score_digit_renderer;

  logic        clock_25;
  logic        reset;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic        score_inc;
  logic        score_clear;
  logic        number_pixel;
  logic [3:0]  selected_number;
  logic [7:0]  number_count;
  logic        score_pixel;
  logic [11:0] score_bcd;

  int n_vec = 0;
  int n_err = 0;

  score_digit_renderer dut (
    .clock_25        (clock_25),
    .reset           (reset),
    .h_count         (h_count),
    .v_count         (v_count),
    .score_inc       (score_inc),
    .score_clear     (score_clear),
    .number_pixel    (number_pixel),
    .selected_number (selected_number),
    .number_count    (number_count),
    .score_pixel     (score_pixel),
    .score_bcd       (score_bcd)
  );

  initial clock_25 = 1'b0;
  always #20 clock_25 = ~clock_25;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       npix;
    logic [3:0] sel;
    logic [7:0] cnt;
    logic       pix;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clock_25);
    @(negedge clock_25);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle_scan();
    h_count = 10'd700;
    v_count = 10'd500;
  endtask

  task automatic inc_n(input int n);
    score_inc = 1'b1;
    repeat (n) tick();
    score_inc = 1'b0;
  endtask

  task automatic load_shadow();
    h_count = 10'd0;
    v_count = 10'd0;
    tick();
    idle_scan();
  endtask

  // One isolated scan position, checked at t+1, t+2 and t+3.
  task automatic scan_check(input string name, input logic [9:0] h, input logic [9:0] v,
                            input logic npix, input logic [3:0] sel,
                            input logic [7:0] cnt, input logic pix);
    h_count      = h;
    v_count      = v;
    number_pixel = npix;
    tick();
    check({name, ".sel"}, 32'(selected_number), 32'(sel));
    idle_scan();
    tick();
    check({name, ".cnt"}, 32'(number_count), 32'(cnt));
    tick();
    check({name, ".pix"}, 32'(score_pixel), 32'(pix));
    number_pixel = 1'b0;
  endtask

  initial begin
    // Shadow score 007 with default origin (16,8) and pitch 12.
    vecs[0]  = '{h: 10'd40, v: 10'd8,  npix: 1'b1, sel: 4'd7, cnt: 8'd0,  pix: 1'b1};
    vecs[1]  = '{h: 10'd26, v: 10'd11, npix: 1'b1, sel: 4'd0, cnt: 8'd0,  pix: 1'b0};
    vecs[2]  = '{h: 10'd15, v: 10'd8,  npix: 1'b1, sel: 4'd0, cnt: 8'd0,  pix: 1'b0};
    vecs[3]  = '{h: 10'd49, v: 10'd17, npix: 1'b1, sel: 4'd7, cnt: 8'd99, pix: 1'b1};
    vecs[4]  = '{h: 10'd49, v: 10'd17, npix: 1'b0, sel: 4'd7, cnt: 8'd99, pix: 1'b0};
    vecs[5]  = '{h: 10'd16, v: 10'd8,  npix: 1'b1, sel: 4'd0, cnt: 8'd0,  pix: 1'b1};
    vecs[6]  = '{h: 10'd51, v: 10'd8,  npix: 1'b1, sel: 4'd0, cnt: 8'd0,  pix: 1'b0};
    vecs[7]  = '{h: 10'd52, v: 10'd8,  npix: 1'b1, sel: 4'd0, cnt: 8'd0,  pix: 1'b0};
    vecs[8]  = '{h: 10'd30, v: 10'd12, npix: 1'b1, sel: 4'd0, cnt: 8'd42, pix: 1'b1};
    vecs[9]  = '{h: 10'd40, v: 10'd18, npix: 1'b1, sel: 4'd0, cnt: 8'd0,  pix: 1'b0};
    vecs[10] = '{h: 10'd40, v: 10'd7,  npix: 1'b1, sel: 4'd0, cnt: 8'd0,  pix: 1'b0};

    reset        = 1'b1;
    score_inc    = 1'b0;
    score_clear  = 1'b0;
    number_pixel = 1'b0;
    idle_scan();
    tick();
    tick();
    reset = 1'b0;
    check("rst.bcd", 32'(score_bcd), 32'h000);
    check("rst.sel", 32'(selected_number), 32'd0);
    check("rst.cnt", 32'(number_count), 32'd0);
    check("rst.pix", 32'(score_pixel), 32'd0);

    inc_n(10);
    check("inc10", 32'(score_bcd), 32'h010);
    inc_n(99);
    check("inc109", 32'(score_bcd), 32'h109);

    score_clear = 1'b1;
    tick();
    score_clear = 1'b0;
    check("clear", 32'(score_bcd), 32'h000);
    inc_n(7);
    check("inc7", 32'(score_bcd), 32'h007);
    load_shadow();

    for (int i = 0; i < 11; i++) begin
      scan_check($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].npix,
                 vecs[i].sel, vecs[i].cnt, vecs[i].pix);
    end

    // Mid-frame increment: live score moves, displayed digits do not.
    inc_n(120);
    check("mid.bcd", 32'(score_bcd), 32'h127);
    scan_check("mid.tens_old", 10'd30, 10'd12, 1'b1, 4'd0, 8'd42, 1'b1);
    scan_check("mid.units_old", 10'd40, 10'd8, 1'b1, 4'd7, 8'd0, 1'b1);
    load_shadow();
    scan_check("new.hund", 10'd16, 10'd8, 1'b1, 4'd1, 8'd0, 1'b1);
    scan_check("new.tens", 10'd30, 10'd12, 1'b1, 4'd2, 8'd42, 1'b1);
    scan_check("new.units", 10'd40, 10'd8, 1'b1, 4'd7, 8'd0, 1'b1);

    // Saturation and clear-over-increment priority.
    inc_n(872);
    check("sat.999", 32'(score_bcd), 32'h999);
    inc_n(1);
    check("sat.hold", 32'(score_bcd), 32'h999);
    score_inc   = 1'b1;
    score_clear = 1'b1;
    tick();
    score_inc   = 1'b0;
    score_clear = 1'b0;
    check("clr_wins", 32'(score_bcd), 32'h000);

    // Reset right after a lit pixel flushes the pipeline.
    inc_n(3);
    load_shadow();
    h_count      = 10'd40;
    v_count      = 10'd8;
    number_pixel = 1'b1;
    tick();
    tick();
    tick();
    check("pre_rst.pix", 32'(score_pixel), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid.pix", 32'(score_pixel), 32'd0);
    check("rst_mid.bcd", 32'(score_bcd), 32'h000);
    tick();
    check("post_rst1.pix", 32'(score_pixel), 32'd0);
    tick();
    check("post_rst2.pix", 32'(score_pixel), 32'd0);
    tick();
    check("post_rst3.pix", 32'(score_pixel), 32'd1);
    check("post_rst3.sel", 32'(selected_number), 32'd0);
    number_pixel = 1'b0;
    idle_scan();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/score_digit_renderer.md
SCORE_DIGIT_RENDERER -- requirements
Module: score_digit_renderer

Interface
REQ-001 Parameter X_ORIGIN, default 16, is the screen column of the leftmost digit's left edge.
REQ-002 Parameter Y_ORIGIN, default 8, is the screen row of the digits' top edge.
REQ-003 Parameter DIGIT_PITCH, default 12, is the horizontal distance between digit left edges (10-pixel glyph plus 2-pixel gap).
REQ-004 clock_25  in  1  pixel clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 h_count  in  10  current scan column, 0..799.
REQ-007 v_count  in  10  current scan row, 0..524.
REQ-008 score_inc  in  1  single-cycle pulse; adds 1 to score.
REQ-009 score_clear  in  1  single-cycle pulse; sets score to 000.
REQ-010 number_pixel  in  1  glyph bit returned by the digit glyph ROM.
REQ-011 selected_number  out  4  BCD digit requested from the glyph ROM.
REQ-012 number_count  out  8  glyph pixel index, row*10+col, 0..99.
REQ-013 score_pixel  out  1  high when the current score pixel is lit.
REQ-014 score_bcd  out  12  live score, {hundreds, tens, units}.

Function
REQ-015 Score is a 3-digit BCD counter, 000..999; score_inc increments with decimal carry per digit (009->010, 099->100).
REQ-016 Score saturates at 999; score_inc at 999 leaves 999.
REQ-017 score_clear and score_inc in the same cycle: clear wins, score becomes 000.
REQ-018 score_bcd updates the cycle after the pulse.
REQ-019 Displayed score is a shadow copy loaded from live score when h_count==0 and v_count==0; the image never changes mid-frame.
REQ-020 Display box: v_count in [Y_ORIGIN, Y_ORIGIN+9] and h_count in [X_ORIGIN, X_ORIGIN+3*DIGIT_PITCH-1]; digit k (0=hundreds) covers columns X_ORIGIN+k*DIGIT_PITCH .. +9; gap columns are not lit.
REQ-021 Stage 0 (registered, cycle t+1 after scan position at t): selected_number = shadow digit k; row r = v_count-Y_ORIGIN, col c = h_count-X_ORIGIN-k*DIGIT_PITCH; in_glyph flag.
REQ-022 The glyph ROM registers selected_number, so number_count = r*10+c SHALL be registered one cycle later than selected_number (cycle t+2), aligning it with the ROM output.
REQ-023 Stage 2: score_pixel = number_pixel AND in_glyph delayed to match, registered at cycle t+3; total latency from h_count/v_count to score_pixel is 3 cycles.
REQ-024 Outside the box or in gap columns: selected_number=0, number_count=0, in_glyph=0, score_pixel=0.
REQ-025 Row/column arithmetic uses 10-bit subtraction evaluated only inside the box; no wrap-around value reaches number_count (always 0..99).
REQ-026 No multiplier inferred for r*10; use (r<<3)+(r<<1).

Reset
REQ-027 reset SHALL clear live score, shadow score, selected_number, number_count, all pipeline flags and score_pixel to 0 on the next rising edge.
REQ-028 reset asserted mid-line or mid-frame discards in-flight pipeline data; score_pixel stays 0 until 3 cycles after valid in-box scan resumes.
REQ-029 reset has priority over score_inc and score_clear.

Verification
REQ-030 Ten score_inc pulses from reset -> score_bcd=12'h010; 99 more -> 12'h109.
REQ-031 Score 999, score_inc -> 999; score_inc with score_clear same cycle -> 000.
REQ-032 Score 7, frame start, scan (X_ORIGIN+24, Y_ORIGIN) -> selected_number=7 at t+1, number_count=0 at t+2, score_pixel=1 at t+3 (ROM model returns 1).
REQ-033 Scan (X_ORIGIN+10, Y_ORIGIN+3) (gap) and (X_ORIGIN-1, Y_ORIGIN) -> score_pixel=0 regardless of number_pixel.
REQ-034 score_inc mid-frame -> displayed digits unchanged until next (0,0); score_bcd updates immediately.
REQ-035 reset asserted one cycle after in-box lit pixel -> score_pixel=0 on following edges, score_bcd=000.
